lcd_test_ctrl: RTL and testbench

//  HD44780-compatible 16x2 character LCD driver, write-only, 8-bit interface.

---
 rtl/lcd_bus_if.sv | 9 +
 rtl/lcd_test_ctrl.sv | 125 ++++++++++++
 tb/tb_lcd_test_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_if.sv
// lcd_bus_if: write-only 8-bit HD44780 bus between the driver and the panel.
interface lcd_bus_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    modport master (output LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
    modport slave  (input  LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
endinterface

// File: rtl/lcd_test_ctrl.sv
// lcd_test_ctrl: HD44780 16x2 driver showing twelve debug bytes as hex.
// Power-up init, then endless line-0/line-1 refresh from a per-frame input snapshot.
module lcd_test_ctrl #(
    parameter int PWRUP_CYC = 1_000_000,
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 16,
    parameter int HOLD_CYC  = 4,
    parameter int WAIT_CYC  = 2_000,
    parameter int CLR_WAIT  = 100_000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] d0x0,
    input  logic [7:0] d0x1,
    input  logic [7:0] d0x2,
    input  logic [7:0] d0x3,
    input  logic [7:0] d0x4,
    input  logic [7:0] d0x5,
    input  logic [7:0] d1x0,
    input  logic [7:0] d1x1,
    input  logic [7:0] d1x2,
    input  logic [7:0] d1x3,
    input  logic [7:0] d1x4,
    input  logic [7:0] d1x5,
    lcd_bus_if.master  lcd
);
    localparam int M0   = PWRUP_CYC > CLR_WAIT ? PWRUP_CYC : CLR_WAIT;
    localparam int M1   = WAIT_CYC > EN_CYC ? WAIT_CYC : EN_CYC;
    localparam int M2   = SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC;
    localparam int M3   = M0 > M1 ? M0 : M1;
    localparam int MAXC = M3 > M2 ? M3 : M2;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {S_PWRUP, S_INIT, S_ADDR0, S_LINE0, S_ADDR1, S_LINE1} state_t;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD, P_WAIT} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d, lim;
    logic [3:0]    idx_q, idx_d;
    logic          en_q;
    logic [7:0]    snap_q [12];
    logic [7:0]    din [12];
    logic [3:0]    grp, sel, nib;
    logic [7:0]    val, cmd, byte_w;
    logic          rs_w, hi, sp;

    assign din = '{d0x0, d0x1, d0x2, d0x3, d0x4, d0x5, d1x0, d1x1, d1x2, d1x3, d1x4, d1x5};

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Column layout: pairs at 0,3,6,9 separated by spaces, then v4/v5 back to back.
    always_comb begin
        grp = idx_q < 4'd2 ? 4'd0 : idx_q < 4'd5 ? 4'd1 : idx_q < 4'd8 ? 4'd2 :
              idx_q < 4'd11 ? 4'd3 : idx_q < 4'd14 ? 4'd4 : 4'd5;
        sel = grp + (state_q == S_LINE1 ? 4'd6 : 4'd0);
        hi  = idx_q inside {4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd14};
        sp  = idx_q inside {4'd2, 4'd5, 4'd8, 4'd11};
        val = snap_q[sel];
        nib = hi ? val[7:4] : val[3:0];
        cmd = state_q == S_INIT ? (idx_q == 4'd0 ? 8'h38 : idx_q == 4'd1 ? 8'h0C :
                                   idx_q == 4'd2 ? 8'h01 : 8'h06) :
              state_q == S_ADDR0 ? 8'h80 : state_q == S_ADDR1 ? 8'hC0 : 8'h00;
        rs_w   = state_q == S_LINE0 || state_q == S_LINE1;
        byte_w = rs_w ? (sp ? 8'h20 : hex_ascii(nib)) : cmd;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        lim = state_q == S_PWRUP ? CW'(PWRUP_CYC - 1) :
              phase_q == P_SETUP ? CW'(SETUP_CYC - 1) :
              phase_q == P_PULSE ? CW'(EN_CYC - 1) :
              phase_q == P_HOLD  ? CW'(HOLD_CYC - 1) :
              (!rs_w && byte_w == 8'h01) ? CW'(CLR_WAIT - 1) : CW'(WAIT_CYC - 1);
        if (cnt_q == lim) begin
            cnt_d = '0;
            if (state_q == S_PWRUP) begin
                state_d = S_INIT;
                phase_d = P_SETUP;
                idx_d   = '0;
            end else if (phase_q != P_WAIT) begin
                phase_d = phase_t'(phase_q + 2'd1);
            end else begin
                phase_d = P_SETUP;
                idx_d   = idx_q + 4'd1;
                case (state_q)
                    S_INIT:  if (idx_q == 4'd3) begin state_d = S_ADDR0; idx_d = '0; end
                    S_ADDR0: begin state_d = S_LINE0; idx_d = '0; end
                    S_LINE0: if (idx_q == 4'd15) state_d = S_ADDR1;
                    S_ADDR1: begin state_d = S_LINE1; idx_d = '0; end
                    S_LINE1: if (idx_q == 4'd15) state_d = S_ADDR0;
                    default: state_d = S_PWRUP;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_PWRUP;
            phase_q <= P_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            en_q    <= 1'b0;
            snap_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= state_d != S_PWRUP && phase_d == P_PULSE;
            if (state_q == S_ADDR0 && phase_q == P_SETUP && cnt_q == '0) snap_q <= din;
        end
    end

    assign lcd.LCD_EN   = en_q;
    assign lcd.LCD_RS   = rs_w;
    assign lcd.LCD_DATA = byte_w;
    assign lcd.LCD_RW   = 1'b0;
endmodule

// File: tb/tb_lcd_test_ctrl.sv
// tb_lcd_test_ctrl: small-parameter bench; a bus monitor captures each byte at the EN fall
// and the main sequence compares captures and strobe timing against a string-built frame model.
module tb_lcd_test_ctrl;
    localparam int PW = 10, SU = 4, EN = 16, HO = 4, WT = 5, CLRW = 20;

    typedef struct { logic [8:0] b; int rise; int fall; int pre; int tot; } cap_t;
    typedef logic [8:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dv [12];
    lcd_bus_if  bus ();

    lcd_test_ctrl #(.PWRUP_CYC(PW), .SETUP_CYC(SU), .EN_CYC(EN), .HOLD_CYC(HO),
                    .WAIT_CYC(WT), .CLR_WAIT(CLRW)) dut (
        .iCLK(clk), .iRST_N(rst_n),
        .d0x0(dv[0]), .d0x1(dv[1]), .d0x2(dv[2]), .d0x3(dv[3]), .d0x4(dv[4]), .d0x5(dv[5]),
        .d1x0(dv[6]), .d1x1(dv[7]), .d1x2(dv[8]), .d1x3(dv[9]), .d1x4(dv[10]), .d1x5(dv[11]),
        .lcd(bus)
    );

    always #5 clk = ~clk;

    cap_t       cap_q [$];
    cap_t       cur_c;
    int         cyc = 0, stab = 0, stab_n;
    logic       en_p = 1'b0, pend = 1'b0, rw_bad = 1'b0;
    logic [8:0] last = 9'h1FF, now_b;

    assign now_b  = {bus.LCD_RS, bus.LCD_DATA};
    assign stab_n = (now_b === last) ? stab + 1 : 1;

    // stab counts consecutive cycles {RS,DATA} has held its value, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.LCD_RW !== 1'b0) rw_bad <= 1'b1;
        if (!rst_n) begin
            en_p <= 1'b0;
            pend <= 1'b0;
            stab <= 0;
            last <= 9'h1FF;
        end else begin
            stab <= stab_n;
            last <= now_b;
            en_p <= bus.LCD_EN;
            if (bus.LCD_EN && !en_p) begin
                cur_c.rise <= cyc;
                cur_c.pre  <= stab_n;
            end
            if (!bus.LCD_EN && en_p) begin
                cur_c.fall <= cyc;
                cur_c.b    <= now_b;
                pend       <= 1'b1;
            end
            if (pend && cyc == cur_c.fall + HO - 1) begin
                cap_q.push_back('{b: cur_c.b, rise: cur_c.rise, fall: cur_c.fall,
                                  pre: cur_c.pre, tot: stab_n});
                pend <= 1'b0;
            end
        end
    end

    int   tests = 0, fails = 0;
    cap_t last_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string hex2(input logic [7:0] b);
        string hx = "0123456789ABCDEF";
        return $sformatf("%c%c", hx[b[7:4]], hx[b[3:0]]);
    endfunction

    function automatic bq_t frame_model(input logic [7:0] v [12]);
        bq_t        q;
        string      ln;
        logic [7:0] ch;
        for (int l = 0; l < 2; l++) begin
            ln = {hex2(v[6*l]), " ", hex2(v[6*l+1]), " ", hex2(v[6*l+2]), " ",
                  hex2(v[6*l+3]), " ", hex2(v[6*l+4]), hex2(v[6*l+5])};
            q.push_back(l == 0 ? 9'h080 : 9'h0C0);
            for (int c = 0; c < 16; c++) begin
                ch = ln[c];
                q.push_back({1'b1, ch});
            end
        end
        return q;
    endfunction

    task automatic expect_cap(input string tag, input logic [8:0] exp);
        int t = 0;
        while (cap_q.size() == 0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({tag, " present"}, 32'(cap_q.size() != 0), 32'd1);
        if (cap_q.size() != 0) begin
            last_c = cap_q.pop_front();
            chk(tag, 32'(last_c.b), 32'(exp));
            chk({tag, " en width"}, last_c.fall - last_c.rise, EN);
            chk({tag, " setup"}, 32'(last_c.pre >= SU + 1), 32'd1);
            chk({tag, " hold"}, 32'(last_c.tot >= SU + EN + HO), 32'd1);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] ev [12], input int chg_at,
                               input logic [7:0] nv [12]);
        bq_t q = frame_model(ev);
        for (int i = 0; i < 34; i++) begin
            expect_cap($sformatf("%s[%0d]", tag, i), q[i]);
            if (i == chg_at) dv = nv;
        end
    endtask

    task automatic quiet_after_reset(input string tag);
        logic seen = 1'b0;
        repeat (PW) begin
            @(posedge clk);
            #1;
            seen |= bus.LCD_EN;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    logic [7:0] f1 [12], nv [12], rv [12], cur [12];
    int         clr_fall, t;

    initial begin
        dv = '{8'h3A, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0,
               8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
        repeat (3) @(posedge clk);
        #1;
        chk("reset en", 32'(bus.LCD_EN), 32'd0);
        chk("reset rs", 32'(bus.LCD_RS), 32'd0);
        chk("reset data", 32'(bus.LCD_DATA), 32'h00);
        chk("reset rw", 32'(bus.LCD_RW), 32'd0);
        rst_n = 1'b1;
        quiet_after_reset("pwrup quiet");
        expect_cap("init0", 9'h038);
        expect_cap("init1", 9'h00C);
        expect_cap("init2", 9'h001);
        clr_fall = last_c.fall;
        expect_cap("init3", 9'h006);
        chk("clear gap", 32'(last_c.rise - clr_fall >= CLRW), 32'd1);

        f1 = dv;
        check_frame("f1", f1, -1, f1);
        nv = dv;
        nv[1] = 8'($urandom_range(1, 255));
        check_frame("f2", f1, 2, nv);
        cur = nv;
        for (int k = 0; k < 3; k++) begin
            foreach (rv[i]) rv[i] = 8'($urandom);
            check_frame($sformatf("fr%0d", k), cur, 17, rv);
            cur = rv;
        end
        check_frame("flast", cur, -1, cur);

        t = 0;
        while (bus.LCD_EN !== 1'b1 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("pulse seen", 32'(bus.LCD_EN), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort en", 32'(bus.LCD_EN), 32'd0);
        chk("abort data", 32'(bus.LCD_DATA), 32'h00);
        chk("abort rs", 32'(bus.LCD_RS), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        cap_q.delete();
        rst_n = 1'b1;
        quiet_after_reset("restart quiet");
        expect_cap("restart0", 9'h038);
        expect_cap("restart1", 9'h00C);
        chk("rw always 0", 32'(rw_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
